// File: rtl/sa_skew_feeder_if.sv
// Load-side handshake for sa_skew_feeder: each beat carries A column k and B row k,
// lane i packed at bits [i*DATA_WIDTH +: DATA_WIDTH].
interface sa_skew_feeder_if #(
    parameter int SIZE       = 8,
    parameter int DATA_WIDTH = 32
);
    logic                       in_valid;
    logic                       in_ready;
    logic [SIZE*DATA_WIDTH-1:0] in_a;
    logic [SIZE*DATA_WIDTH-1:0] in_b;

    modport master (output in_valid, output in_a, output in_b, input in_ready);
    modport slave  (input in_valid, input in_a, input in_b, output in_ready);
endinterface

// File: rtl/sa_skew_feeder.sv
// Operand feeder for SystolicArray: buffers one SIZE x SIZE A/B pair and replays it as skewed wavefronts.
// Define SA_FEED_DBUF_EN for ping-pong buffering so the next frame loads while the current one issues.
//
// state | meaning
// IDLE  | one cycle after reset release
// LOAD  | accepting beats into the fill bank, nothing issuing
// CLR   | clear the array accumulators (sa_rst_n low on the output stage)
// ISSUE | wavefronts t = 0 .. 2*SIZE-2
// DRAIN | DRAIN_CYCLES zero beats, frame_done on the last one
module sa_skew_feeder #(
    parameter int SIZE         = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int DRAIN_CYCLES = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    sa_skew_feeder_if.slave            ld,
    output logic [SIZE*DATA_WIDTH-1:0] a_out,
    output logic [SIZE*DATA_WIDTH-1:0] b_out,
    output logic                       sa_rst_n,
    output logic                       busy,
    output logic                       frame_done
);

    localparam int KW  = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int TW  = $clog2(2 * SIZE);
    localparam int DCW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CLR, S_ISSUE, S_DRAIN} state_t;

    state_t           state_q, state_d;
    logic [KW-1:0]    beat_q, beat_d;
    logic [TW-1:0]    t_q, t_d;
    logic [DCW-1:0]   drain_q, drain_d;
    logic             in_ready_q, in_ready_d;
    logic             accept, fill_done, frame_end;
    logic [SIZE*DATA_WIDTH-1:0] a_nx, b_nx;
    int               idx;

`ifdef SA_FEED_DBUF_EN
    localparam int NB = 2;
    logic fill_bank_q, fill_bank_d, iss_bank_q, iss_bank_d, fill_full_q, fill_full_d;
`else
    localparam int NB = 1;
    logic fill_bank_q, iss_bank_q;
    assign fill_bank_q = 1'b0;
    assign iss_bank_q  = 1'b0;
`endif

    logic [DATA_WIDTH-1:0] a_buf [NB][SIZE][SIZE];
    logic [DATA_WIDTH-1:0] b_buf [NB][SIZE][SIZE];

    assign ld.in_ready = in_ready_q;
    assign accept      = ld.in_valid && in_ready_q;
    assign fill_done   = accept && (beat_q == KW'(SIZE - 1));

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        t_d       = t_q;
        drain_d   = drain_q;
        frame_end = 1'b0;
`ifdef SA_FEED_DBUF_EN
        fill_bank_d = fill_bank_q;
        iss_bank_d  = iss_bank_q;
        fill_full_d = fill_full_q;
`endif
        if (accept) beat_d = fill_done ? '0 : beat_q + 1'b1;

        unique case (state_q)
            S_IDLE: state_d = S_LOAD;
            S_LOAD: begin
                if (fill_done) begin
                    state_d = S_CLR;
`ifdef SA_FEED_DBUF_EN
                    iss_bank_d  = fill_bank_q;
                    fill_bank_d = ~fill_bank_q;
`endif
                end
            end
            S_CLR: begin
                state_d = S_ISSUE;
                t_d     = '0;
            end
            S_ISSUE: begin
                if (t_q == TW'(2 * SIZE - 2)) begin
                    if (DRAIN_CYCLES == 0) begin
                        frame_end = 1'b1;
                    end else begin
                        state_d = S_DRAIN;
                        drain_d = DCW'(DRAIN_CYCLES - 1);
                    end
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain_q == '0) frame_end = 1'b1;
                else               drain_d   = drain_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

`ifdef SA_FEED_DBUF_EN
        // A fill completing while a frame is in flight parks until the frame ends.
        if (state_q != S_LOAD && fill_done) fill_full_d = 1'b1;
        if (frame_end) begin
            if (fill_full_q || fill_done) begin
                state_d     = S_CLR;
                iss_bank_d  = fill_bank_q;
                fill_bank_d = iss_bank_q;
                fill_full_d = 1'b0;
            end else begin
                state_d = S_LOAD;
            end
        end
        in_ready_d = (state_d != S_IDLE) && !fill_full_d;
`else
        if (frame_end) state_d = S_LOAD;
        in_ready_d = (state_d == S_LOAD);
`endif
    end

    // Lane i of A lags by i cycles; B lane j indexes rows the same way.
    always_comb begin
        a_nx = '0;
        b_nx = '0;
        idx  = 0;
        if (state_q == S_ISSUE) begin
            for (int i = 0; i < SIZE; i++) begin
                idx = int'(t_q) - i;
                if (idx >= 0 && idx < SIZE) begin
                    a_nx[i*DATA_WIDTH +: DATA_WIDTH] = a_buf[iss_bank_q][KW'(i)][KW'(idx)];
                    b_nx[i*DATA_WIDTH +: DATA_WIDTH] = b_buf[iss_bank_q][KW'(idx)][KW'(i)];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < SIZE; i++) begin
                a_buf[fill_bank_q][KW'(i)][beat_q] <= ld.in_a[i*DATA_WIDTH +: DATA_WIDTH];
                b_buf[fill_bank_q][beat_q][KW'(i)] <= ld.in_b[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Output stage trails the state register by one cycle, giving the 2-cycle load-to-wavefront latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            beat_q     <= '0;
            t_q        <= '0;
            drain_q    <= '0;
            in_ready_q <= 1'b0;
            a_out      <= '0;
            b_out      <= '0;
            sa_rst_n   <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
`ifdef SA_FEED_DBUF_EN
            fill_bank_q <= 1'b0;
            iss_bank_q  <= 1'b0;
            fill_full_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            t_q        <= t_d;
            drain_q    <= drain_d;
            in_ready_q <= in_ready_d;
            a_out      <= a_nx;
            b_out      <= b_nx;
            sa_rst_n   <= (state_q != S_CLR);
            busy       <= (state_q == S_CLR) || (state_q == S_ISSUE) || (state_q == S_DRAIN);
            frame_done <= frame_end;
`ifdef SA_FEED_DBUF_EN
            fill_bank_q <= fill_bank_d;
            iss_bank_q  <= iss_bank_d;
            fill_full_q <= fill_full_d;
`endif
        end
    end

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Scoreboard bench for sa_skew_feeder: captured load beats feed a matrix-level model whose
// expected wavefronts are queued and popped by an output monitor on every issue/drain beat.
module tb_sa_skew_feeder;

    localparam int SIZE  = 8;
    localparam int DW    = 32;
    localparam int DRAIN = 8;
    localparam int W     = SIZE * DW;
    localparam int FRAME = 2 * SIZE + DRAIN;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] a_out, b_out;
    logic         sa_rst_n, busy, frame_done;

    sa_skew_feeder_if #(.SIZE(SIZE), .DATA_WIDTH(DW)) ld ();

    sa_skew_feeder #(.SIZE(SIZE), .DATA_WIDTH(DW), .DRAIN_CYCLES(DRAIN)) dut (
        .clk        (clk),
        .rst        (rst),
        .ld         (ld),
        .a_out      (a_out),
        .b_out      (b_out),
        .sa_rst_n   (sa_rst_n),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         done;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         mon_e;
    int           errors = 0;
    int           checks = 0;
    logic [DW-1:0] ma [SIZE][SIZE];
    logic [DW-1:0] mb [SIZE][SIZE];
    int           nbeat = 0;
    logic [W-1:0] beat_a [SIZE];
    logic [W-1:0] beat_b [SIZE];
    logic [W-1:0] hist_a [2*SIZE-1];
    logic [W-1:0] hist_b [2*SIZE-1];
    int           cyc = 0;
    bit           streaming = 1'b0;
    int           last_pulse = -1;
    int           frames_seen = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // C = A*B matrices as the array would see them: A[i][k] enters row i at time k+i, B[k][j] column j at k+j.
    task automatic build_expect();
        exp_t e;
        for (int t = 0; t < 2 * SIZE - 1; t++) begin
            e.a = '0;
            e.b = '0;
            for (int i = 0; i < SIZE; i++) begin
                if (t - i >= 0 && t - i < SIZE) begin
                    e.a[i*DW +: DW] = ma[i][t-i];
                    e.b[i*DW +: DW] = mb[t-i][i];
                end
            end
            e.done = (DRAIN == 0) && (t == 2 * SIZE - 2);
            exp_q.push_back(e);
        end
        for (int d = 0; d < DRAIN; d++) begin
            e.a    = '0;
            e.b    = '0;
            e.done = (d == DRAIN - 1);
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            exp_q.delete();
            nbeat = 0;
        end else begin
            if (busy && sa_rst_n) begin
                if (exp_q.size() == 0) begin
                    chk("sb_nonempty", W'(0), W'(1));
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("a_out", a_out, mon_e.a);
                    chk("b_out", b_out, mon_e.b);
                    chk("frame_done", W'(frame_done), W'(mon_e.done));
                    if (frame_done && mon_e.done) frames_seen++;
                end
            end else begin
                chk("quiet_a", a_out, '0);
                chk("quiet_b", b_out, '0);
                chk("quiet_frame_done", W'(frame_done), '0);
            end
            if (!sa_rst_n) begin
                if (streaming && last_pulse >= 0) chk("clr_spacing", W'(cyc - last_pulse), W'(FRAME));
                last_pulse = cyc;
            end
`ifndef SA_FEED_DBUF_EN
            if (busy && !frame_done) chk("ready_low_busy", W'(ld.in_ready), '0);
`endif
            if (ld.in_valid && ld.in_ready) begin
                for (int i = 0; i < SIZE; i++) begin
                    ma[i][nbeat] = ld.in_a[i*DW +: DW];
                    mb[nbeat][i] = ld.in_b[i*DW +: DW];
                end
                nbeat++;
                if (nbeat == SIZE) begin
                    build_expect();
                    nbeat = 0;
                end
            end
        end
    end

    task automatic rand_fill();
        for (int k = 0; k < SIZE; k++) begin
            beat_a[k] = rand_word();
            beat_b[k] = rand_word();
        end
    endtask

    task automatic send_frame(input bit toggle);
        int k = 0;
        int n = 0;
        bit ph = 1'b1;
        bit acc;
        while (k < SIZE && n < 200) begin
            ld.in_valid = toggle ? ph : 1'b1;
            ld.in_a     = ld.in_valid ? beat_a[k] : rand_word();
            ld.in_b     = ld.in_valid ? beat_b[k] : rand_word();
            ph          = !ph;
            @(negedge clk);
            acc = ld.in_valid && ld.in_ready;
            @(posedge clk);
            #1;
            if (acc) k++;
            n++;
        end
        ld.in_valid = 1'b0;
        ld.in_a     = rand_word();
        ld.in_b     = rand_word();
        if (k < SIZE) chk("send_timeout", W'(k), W'(SIZE));
        if (toggle) chk("toggle_load_cycles", W'(n), W'(2 * SIZE - 1));
    endtask

    task automatic wait_frames(input int target);
        int n = 0;
        while (frames_seen < target && n < 400) begin
            @(posedge clk);
            n++;
        end
        chk("frames_done", W'(frames_seen), W'(target));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        ld.in_valid = 1'b0;
        ld.in_a     = '0;
        ld.in_b     = '0;

        // reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", W'(ld.in_ready), '0);
        chk("rst_a_out", a_out, '0);
        chk("rst_b_out", b_out, '0);
        chk("rst_sa_rst_n", W'(sa_rst_n), W'(1));
        chk("rst_busy", W'(busy), '0);
        chk("rst_frame_done", W'(frame_done), '0);
        rst = 1'b1;
        #1;
        chk("release_ready_pre", W'(ld.in_ready), '0);
        @(posedge clk);
        #1;
        chk("release_ready_post", W'(ld.in_ready), W'(1));

        // directed frame with latency probes
        rand_fill();
        beat_a[0][0 +: DW] = 37;  beat_a[0][DW +: DW] = 45;  beat_b[0][0 +: DW] = 2;
        beat_a[1][0 +: DW] = 60;  beat_a[1][DW +: DW] = 45;
        beat_b[1][0 +: DW] = 47;  beat_b[1][DW +: DW] = 30;
        send_frame(1'b0);
        @(posedge clk);
        #1;
        chk("t2_clr_low", W'(sa_rst_n), '0);
        chk("t2_clr_busy", W'(busy), W'(1));
        @(posedge clk);
        #1;
        chk("t2_wave0_a", a_out, W'(37));
        chk("t2_wave0_b", b_out, W'(2));
        @(posedge clk);
        #1;
        chk("t2_wave1_lane0", W'(a_out[0 +: DW]), W'(60));
        chk("t2_wave1_lane1", W'(a_out[DW +: DW]), W'(45));
        wait_frames(1);

        // same operands with in_valid toggling
        send_frame(1'b1);
        wait_frames(2);

        // reset mid-ISSUE, then a fresh frame
        rand_fill();
        send_frame(1'b0);
        repeat (6) @(posedge clk);
        #1;
        chk("t4_busy_before", W'(busy), W'(1));
        rst = 1'b0;
        #1;
        chk("t4_a_zero", a_out, '0);
        chk("t4_b_zero", b_out, '0);
        chk("t4_busy", W'(busy), '0);
        chk("t4_sa_rst_n", W'(sa_rst_n), W'(1));
        chk("t4_in_ready", W'(ld.in_ready), '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t4_ready_again", W'(ld.in_ready), W'(1));
        rand_fill();
        send_frame(1'b0);
        wait_frames(3);

        // identity operands; also replay the stream through a behavioural array
        for (int k = 0; k < SIZE; k++) begin
            beat_a[k] = W'(1) << (k * DW);
            beat_b[k] = W'(1) << (k * DW);
        end
        send_frame(1'b0);
        @(posedge clk);
        #1;
        for (int t = 0; t < 2 * SIZE - 1; t++) begin
            @(posedge clk);
            #1;
            hist_a[t] = a_out;
            hist_b[t] = b_out;
            chk("t5_ident_a", a_out, (t % 2 == 0) ? (W'(1) << ((t / 2) * DW)) : '0);
        end
        for (int i = 0; i < SIZE; i++) begin
            for (int j = 0; j < SIZE; j++) begin
                acc = 0;
                for (int t = 0; t <= 3 * SIZE - 3; t++) begin
                    if (t - j >= 0 && t - j < 2 * SIZE - 1 && t - i >= 0 && t - i < 2 * SIZE - 1)
                        acc += int'(hist_a[t-j][i*DW +: DW]) * int'(hist_b[t-i][j*DW +: DW]);
                end
                chk("t5_c_elem", W'(acc), W'(i == j));
            end
        end
        wait_frames(4);

`ifdef SA_FEED_DBUF_EN
        // three frames streamed back to back
        streaming  = 1'b1;
        last_pulse = -1;
        for (int f = 0; f < 3; f++) begin
            rand_fill();
            send_frame(1'b0);
        end
        wait_frames(7);
        streaming = 1'b0;
`endif

        repeat (5) @(posedge clk);
        #1;
        chk("sb_drained", W'(exp_q.size()), '0);
        chk("model_partial", W'(nbeat), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
